uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Serial receiver for the PID board's host link; directly downstream of the transmitter's `tx` line; also receives host-side setpoint/gain bytes.
- Oversamples the line at 16x baud, validates the start bit, majority-votes each bit, checks the stop bit.
- Presents each received byte on a valid/ready handshake to the command parser.
- Flags framing errors and overruns.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD_RATE, 9600, line baud rate.
- OS_DIV, CLK_FREQ/(BAUD_RATE*16) = 325, clocks per oversample tick (localparam, integer truncation).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rx  in  1  asynchronous serial input; idles high.
- data_out  out  8  received byte, valid while data_valid=1.
- data_valid  out  1  byte available; held until accepted.
- data_ready  in  1  consumer accepts when data_valid & data_ready on a rising edge.
- frame_err  out  1  one-cycle pulse: stop bit sampled 0.
- overrun  out  1  one-cycle pulse: new byte dropped because previous byte not accepted.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values (all asynchronous on reset_n=0):
  - data_out=0, data_valid=0, frame_err=0, overrun=0, busy=0.
  - State=IDLE, all counters 0.
  - Synchronizer flops=1; edge-history flop=0.
- Input conditioning:
  - 2-flop synchronizer produces rx_s.
  - rx_prev holds the previous rx_s.
  - Falling edge = rx_prev & ~rx_s.
  - rx_prev resets to 0, so a line already low at reset release is not a start; the line must be seen high first.
- Tick generator:
  - tick_cnt counts 0..OS_DIV-1; tick is asserted for one cycle when tick_cnt==OS_DIV-1.
  - tick_cnt and os_cnt (0..15, counts ticks within a bit) clear to 0 on IDLE->START.
- Bit sampling:
  - Samples are taken at os_cnt = 7, 8, 9.
  - The majority of the 3 samples is the bit value, decided on the tick where os_cnt==9.
  - The bit ends on the tick where os_cnt==15; os_cnt then wraps to 0.
- State machine:
  - IDLE: on a falling edge go to START.
  - START: at the os_cnt==9 decision:
    - majority 1 -> IDLE (glitch rejected, no flags);
    - majority 0 -> continue, and enter DATA at os_cnt wrap.
  - DATA:
    - shift the majority bit in LSB-first at each os_cnt==9 decision (shift_reg <= {bit, shift_reg[7:1]});
    - bit_idx counts 0..7;
    - after bit 7's wrap go to STOP.
  - STOP, at the os_cnt==9 decision:
    - majority 1: deliver the byte (see handshake), then go to IDLE immediately. Do not wait for the remainder of the stop bit; this allows back-to-back frames.
    - majority 0: pulse frame_err, discard the byte, go to BREAK.
  - BREAK: wait for rx_s==1, then go to IDLE. A held-low break produces exactly one frame_err.
- Handshake / delivery, evaluated on the delivery cycle:
  - If data_valid=0, or data_valid & data_ready in the same cycle: load data_out and set data_valid=1. No overrun.
  - Otherwise: keep the old data_out and data_valid=1, drop the new byte, pulse overrun.
  - If data_valid & data_ready with no delivery: data_valid goes 0 next cycle. data_out holds its value.
- Timing:
  - Latency from the stop-bit centre decision to data_valid rising is 1 clock.
  - A byte arrives ~9.5 bit times after the start edge.
  - The receiver tolerates up to ±3% baud mismatch (the transmitter at 5208 clk/bit vs receiver 5200 is 0.15%).
- Reset mid-frame: the frame is abandoned with no flags. After release, the block needs a high line, then a falling edge, before a new frame starts.

Decomposition:
- Shared package uart_pkg holds:
  - the state encoding (IDLE, START, DATA, STOP, BREAK);
  - OS_RATE=16, SAMPLE_A=7, SAMPLE_B=8, SAMPLE_C=9, BIT_END=15, DATA_BITS=8.
- One sub-module: uart_baud_tick (parameter DIV, inputs clk/reset_n/clear, output tick). It is reusable by the transmitter later.

Test Plan:
- Loopback: uart_tx sends 0xA5 into rx with data_ready=1 -> one data_valid pulse, data_out=0xA5, frame_err=0, overrun=0.
- Back-to-back: bytes 0x00, 0xFF, 0x3C sent with no idle gap, data_ready=1 -> three deliveries in order, each ~52000 clocks apart.
- Glitch: rx low for 2000 clocks (< half bit), then high -> busy returns 0 after the START decision; no data_valid, no flags.
- Framing/break: frame 0x55 with stop bit forced 0, then line held low for 20 bit times -> exactly one frame_err pulse, no data_valid. After rx goes high, 0x12 is received correctly.
- Overrun: data_ready=0; send 0x11 then 0x22 -> data_valid=1, data_out=0x11, one overrun pulse at the second stop. Raising data_ready -> data_valid drops next cycle. A simultaneous ready+delivery case loads the new byte without overrun.
- Reset mid-frame: assert reset_n=0 during bit 4 of 0x96 -> all outputs 0 immediately, state IDLE. Line low at release -> no start until a high then a falling edge; the following 0x96 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the host-link UART receiver (and later transmitter).
// State encoding, oversampling constants and the bit-vote helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    localparam int OS_RATE   = 16;
    localparam int SAMPLE_A  = 7;
    localparam int SAMPLE_B  = 8;
    localparam int SAMPLE_C  = 9;
    localparam int BIT_END   = 15;
    localparam int DATA_BITS = 8;

    function automatic logic maj3(
        input logic a,
        input logic b,
        input logic c
    );
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV clocks.
// A synchronous clear restarts the period so ticks align to a start edge.
module uart_baud_tick #(
    parameter int DIV = 325
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] r_cnt;

    assign tick = (r_cnt == W'(DIV - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (clear || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 16x oversampled UART receiver with 3-sample majority vote,
// valid/ready byte delivery, framing-error and overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 9600
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    input  logic       data_ready,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int OS_DIV = CLK_FREQ / (BAUD_RATE * OS_RATE);

    logic       r_sync1;
    logic       r_sync2;
    logic       r_rx_prev;
    logic [1:0] r_warm;

    state_t     r_state;
    logic [3:0] r_os_cnt;
    logic [2:0] r_bit_idx;
    logic [1:0] r_samp;
    logic [7:0] r_shift;

    logic w_rx_s;
    logic w_fall;
    logic w_tick;
    logic w_clear;
    logic w_maj;
    logic w_decide;

    assign w_rx_s   = r_sync2;
    assign w_fall   = r_rx_prev & ~w_rx_s;
    assign w_clear  = (r_state == ST_IDLE) & w_fall;
    assign w_maj    = maj3(r_samp[0], r_samp[1], w_rx_s);
    assign w_decide = w_tick & (r_os_cnt == 4'(SAMPLE_C));

    uart_baud_tick #(
        .DIV(OS_DIV)
    ) u_tick (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (w_clear),
        .tick   (w_tick)
    );

    // The preset synchronizer values are not line history, so the
    // edge detector only sees samples that actually came from rx.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b0;
            r_warm    <= 2'b00;
        end else begin
            r_sync1   <= rx;
            r_sync2   <= r_sync1;
            r_warm    <= {r_warm[0], 1'b1};
            r_rx_prev <= r_sync2 & r_warm[1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_os_cnt   <= '0;
            r_bit_idx  <= '0;
            r_samp     <= '0;
            r_shift    <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
            if (w_tick) begin
                r_os_cnt <= r_os_cnt + 1'b1;
                if (r_os_cnt == 4'(SAMPLE_A)) r_samp[0] <= w_rx_s;
                if (r_os_cnt == 4'(SAMPLE_B)) r_samp[1] <= w_rx_s;
            end
            unique case (r_state)
                ST_IDLE: begin
                    if (w_fall) begin
                        r_state   <= ST_START;
                        r_os_cnt  <= '0;
                        r_bit_idx <= '0;
                        busy      <= 1'b1;
                    end
                end
                ST_START: begin
                    if (w_decide && w_maj) begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end else if (w_tick && r_os_cnt == 4'(BIT_END)) begin
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_decide) begin
                        r_shift <= {w_maj, r_shift[7:1]};
                    end
                    if (w_tick && r_os_cnt == 4'(BIT_END)) begin
                        if (r_bit_idx == 3'(DATA_BITS - 1)) begin
                            r_state <= ST_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (w_decide) begin
                        if (w_maj) begin
                            // Finish at stop-bit centre so a following
                            // start edge is never missed.
                            r_state <= ST_IDLE;
                            busy    <= 1'b0;
                            if (!data_valid || data_ready) begin
                                data_out   <= r_shift;
                                data_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            r_state   <= ST_BREAK;
                        end
                    end
                end
                ST_BREAK: begin
                    if (w_rx_s) begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial line driver, byte/flag
// expectation queues, and a per-cycle monitor comparing against them.
module tb_uart_rx;

    localparam int CLK_FREQ = 1600000;
    localparam int BAUD     = 25000;
    localparam int BIT      = 64;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       rx;
    logic       data_ready;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [7:0] exp_q[$];
    int         exp_t[$];
    int         err_exp = 0;
    int         ovr_exp = 0;

    uart_rx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD_RATE(BAUD)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx        (rx),
        .data_ready(data_ready),
        .data_out  (data_out),
        .data_valid(data_valid),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every flag pulse and every accepted byte must be expected.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (frame_err) begin
                n_chk++;
                if (err_exp > 0) err_exp--;
                else begin
                    n_fail++;
                    $display("FAIL frame_err: got pulse expected none (cyc %0d)", cyc);
                end
            end
            if (overrun) begin
                n_chk++;
                if (ovr_exp > 0) ovr_exp--;
                else begin
                    n_fail++;
                    $display("FAIL overrun: got pulse expected none (cyc %0d)", cyc);
                end
            end
            if (data_valid && data_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL rx_byte: got %0h expected no byte (cyc %0d)", data_out, cyc);
                end else begin
                    automatic logic [7:0] e = exp_q.pop_front();
                    automatic int t = exp_t.pop_front();
                    check("rx_byte", data_out, e);
                    if (t >= 0) begin
                        n_chk++;
                        if (cyc - t < 9 * BIT || cyc - t > 10 * BIT) begin
                            n_fail++;
                            $display("FAIL latency: got %0d expected %0d..%0d",
                                     cyc - t, 9 * BIT, 10 * BIT);
                        end
                    end
                end
            end
        end
    end

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        hold(n);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b,
                              input int blen);
        rx = 1'b0;
        hold(blen);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            hold(blen);
        end
        rx = stop_b;
        hold(blen);
        rx = 1'b1;
    endtask

    task automatic expect_send(input logic [7:0] d, input int blen,
                               input bit timed);
        exp_q.push_back(d);
        exp_t.push_back(timed ? cyc : -1);
        send_frame(d, 1'b1, blen);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected end of test");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        rx         = 1'b1;
        data_ready = 1'b1;
        reset_n    = 1'b0;
        hold(5);
        check("rst_data_out", data_out, 0);
        check("rst_valid", data_valid, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
        reset_n = 1'b1;
        idle(20);

        expect_send(8'hA5, BIT, 1);
        idle(2 * BIT);
        check("loopback_data", data_out, 8'hA5);

        expect_send(8'h00, BIT, 1);
        expect_send(8'hFF, BIT, 1);
        expect_send(8'h3C, BIT, 1);
        idle(2 * BIT);
        check("b2b_last", data_out, 8'h3C);
        check("b2b_drained", exp_q.size(), 0);

        rx = 1'b0;
        hold(20);
        rx = 1'b1;
        check("glitch_busy", busy, 1);
        idle(BIT);
        check("glitch_idle", busy, 0);
        check("glitch_valid", data_valid, 0);

        err_exp = err_exp + 1;
        send_frame(8'h55, 1'b0, BIT);
        rx = 1'b0;
        hold(19 * BIT);
        check("break_busy", busy, 1);
        idle(BIT);
        check("break_idle", busy, 0);
        expect_send(8'h12, BIT, 1);
        idle(2 * BIT);
        check("break_one_err", err_exp, 0);
        check("after_break", data_out, 8'h12);

        data_ready = 1'b0;
        exp_q.push_back(8'h11);
        exp_t.push_back(-1);
        ovr_exp = ovr_exp + 1;
        send_frame(8'h11, 1'b1, BIT);
        send_frame(8'h22, 1'b1, BIT);
        idle(2 * BIT);
        check("ovr_valid", data_valid, 1);
        check("ovr_data", data_out, 8'h11);
        check("ovr_one_pulse", ovr_exp, 0);
        data_ready = 1'b1;
        hold(1);
        check("ovr_valid_drop", data_valid, 0);
        check("ovr_data_hold", data_out, 8'h11);

        data_ready = 1'b0;
        exp_q.push_back(8'h33);
        exp_t.push_back(-1);
        d = 0;
        fork
            send_frame(8'h33, 1'b1, BIT);
            begin
                while (!data_valid && d < 3000) begin
                    hold(1);
                    d++;
                end
            end
        join
        check("sim_measure", d < 3000, 1);
        idle(BIT);
        exp_q.push_back(8'h44);
        exp_t.push_back(-1);
        fork
            send_frame(8'h44, 1'b1, BIT);
            begin
                hold(d - 1);
                data_ready = 1'b1;
            end
        join
        idle(2 * BIT);
        check("sim_data", data_out, 8'h44);
        check("sim_drained", exp_q.size(), 0);

        rx = 1'b0;
        hold(BIT);
        for (int i = 0; i < 4; i++) begin
            rx = (8'h96 >> i) & 1;
            hold(BIT);
        end
        rx = 1'b1;
        hold(BIT / 2);
        check("mid_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", data_valid, 0);
        check("mid_rst_data", data_out, 0);
        rx = 1'b0;
        hold(4);
        reset_n = 1'b1;
        hold(10 * BIT);
        check("low_no_start", busy, 0);
        check("low_no_valid", data_valid, 0);
        idle(BIT);
        expect_send(8'h96, BIT, 1);
        idle(2 * BIT);
        check("mid_recover", data_out, 8'h96);

        for (int n = 0; n < 30; n++) begin
            int kind;
            int blen;
            logic [7:0] b;
            kind = $urandom_range(0, 9);
            blen = BIT - 1 + $urandom_range(0, 2);
            b    = 8'($urandom);
            if (kind <= 6) begin
                expect_send(b, blen, 1);
                idle($urandom_range(0, 12));
            end else if (kind <= 8) begin
                err_exp = err_exp + 1;
                send_frame(b, 1'b0, blen);
                idle(8 + $urandom_range(0, 12));
            end else begin
                rx = 1'b0;
                hold($urandom_range(1, 20));
                idle(BIT + 8);
            end
        end
        idle(3 * BIT);
        check("end_bytes_left", exp_q.size(), 0);
        check("end_err_left", err_exp, 0);
        check("end_ovr_left", ovr_exp, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
